// File: rtl/serial_bit_tx.sv
// serial_bit_tx: frames a parallel word as start, LSB-first data, optional even parity and stop bits on a registered idle-high serial line.
module serial_bit_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              q,
    output logic              busy,
    output logic              done
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = (DATA_W > 0) ? $clog2(DATA_W + 1) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t            state, state_next;
    logic [CW-1:0]     cnt, cnt_next;
    logic [IW-1:0]     idx, idx_next;
    logic [DATA_W-1:0] shift, shift_next;
    logic              par, par_next, q_next, done_next, bit_end, last_bit, accept;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_next;

    always_comb begin
        bit_end    = cnt == CW'(CLKS_PER_BIT - 1);
        last_bit   = idx == IW'(DATA_W - 1);
        state_next = state;
        case (state)
            IDLE:    if (din_valid) state_next = START;
            START:   if (bit_end) state_next = DATA;
            DATA:    if (bit_end && last_bit) state_next = (PARITY_EN != 0) ? PARITY : STOP;
            PARITY:  if (bit_end) state_next = STOP;
            STOP:    if (bit_end) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // q is computed from the upcoming state so the line register changes exactly at bit boundaries
    always_comb begin
        busy       = state != IDLE;
        din_ready  = !busy && rst_n;
        accept     = state == IDLE && din_valid;
        cnt_next   = (busy && !bit_end) ? cnt + CW'(1) : '0;
        idx_next   = (state != DATA) ? '0 : !bit_end ? idx : last_bit ? '0 : idx + IW'(1);
        shift_next = accept ? din : (state == DATA && bit_end) ? shift >> 1 : shift;
        par_next   = accept ? ^din : par;
        q_next     = (state_next == START)  ? 1'b0 :
                     (state_next == DATA)   ? shift_next[0] :
                     (state_next == PARITY) ? par : 1'b1;
        done_next  = state == STOP && bit_end;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cnt   <= '0;
            idx   <= '0;
            shift <= '0;
            par   <= 1'b0;
            q     <= 1'b1;
            done  <= 1'b0;
        end else begin
            cnt   <= cnt_next;
            idx   <= idx_next;
            shift <= shift_next;
            par   <= par_next;
            q     <= q_next;
            done  <= done_next;
        end
endmodule

// File: tb/tb_serial_bit_tx.sv
// tb_serial_bit_tx: directed checks of framing, timing, back-to-back, reset abort and a small 4-bit no-parity variant.
module tb_serial_bit_tx;
    logic       clk, rst_n;
    logic [7:0] din;
    logic       din_valid, din_ready, q, busy, done;
    logic [3:0] b_din;
    logic       b_valid, b_ready, b_q, b_busy, b_done;
    int         errors = 0;
    int         checks = 0;

    serial_bit_tx dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .q(q), .busy(busy), .done(done)
    );

    serial_bit_tx #(.DATA_W(4), .CLKS_PER_BIT(1), .PARITY_EN(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .din(b_din), .din_valid(b_valid),
        .din_ready(b_ready), .q(b_q), .busy(b_busy), .done(b_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Entered at the negedge of cycle 1 after the accepting edge; leaves at cycle 45 (done cycle).
    task automatic check_frame(input logic [7:0] w, input logic noise);
        logic [10:0] bits;
        bits = {1'b1, ^w, w, 1'b0};
        for (int i = 0; i < 44; i++) begin
            if (noise && i == 8) begin
                din_valid = 1'b1;
                din = 8'h3C;
            end
            if (noise && i == 20) din_valid = 1'b0;
            chk("q_bit", q, bits[i/4]);
            chk("busy", busy, 1);
            chk("ready_low", din_ready, 0);
            chk("done_low", done, 0);
            @(negedge clk);
        end
        chk("done_pulse", done, 1);
        chk("ready_done", din_ready, 1);
        chk("q_idle_done", q, 1);
    endtask

    initial begin
        logic [5:0] b_exp;
        b_exp = 6'b110010;
        rst_n = 1'b0;
        din = '0;
        din_valid = 1'b0;
        b_din = '0;
        b_valid = 1'b0;
        repeat (2) @(negedge clk);
        din_valid = 1'b1;
        b_valid = 1'b1;
        @(negedge clk);
        chk("rst_q", q, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", din_ready, 0);
        chk("rst_b_ready", b_ready, 0);
        din_valid = 1'b0;
        b_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("ready_after_rst", din_ready, 1);
        b_din = 4'b1001;
        b_valid = 1'b1;
        @(negedge clk);
        b_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("b_q", b_q, b_exp[i]);
            chk("b_busy", b_busy, 1);
            chk("b_done_low", b_done, 0);
            @(negedge clk);
        end
        chk("b_done", b_done, 1);
        chk("b_q_idle", b_q, 1);
        @(negedge clk);
        chk("b_done_end", b_done, 0);

        din = 8'hA5;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        check_frame(8'hA5, 1'b1);
        @(negedge clk);
        chk("a5_done_end", done, 0);
        chk("a5_idle_busy", busy, 0);

        din = 8'h07;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        din = 8'hFF;
        check_frame(8'h07, 1'b0);
        @(negedge clk);
        chk("07_done_end", done, 0);

        din = 8'h01;
        din_valid = 1'b1;
        @(negedge clk);
        din = 8'h80;
        check_frame(8'h01, 1'b0);
        @(negedge clk);
        din_valid = 1'b0;
        check_frame(8'h80, 1'b0);
        @(negedge clk);
        chk("b2b_done_end", done, 0);
        chk("b2b_idle", busy, 0);

        din = 8'hFF;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        repeat (17) @(negedge clk);
        chk("pre_abort_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_q", q, 1);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_ready", din_ready, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            chk("abort_no_done", done, 0);
            chk("abort_q_idle", q, 1);
            @(negedge clk);
        end

        din = 8'h55;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        check_frame(8'h55, 1'b0);
        @(negedge clk);
        chk("55_done_end", done, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
